// File: rtl/divider_pkg.sv
// divider_pkg: state encoding and requester indices shared by divider_arbiter
// and rr_arbiter2.
package divider_pkg;

  // Controller states, binary encoded.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    WAIT = 2'b10,
    ACK  = 2'b11
  } state_t;

  // Bit positions of each requester inside a one-hot grant vector.
  localparam int REQ_A = 0;
  localparam int REQ_B = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter. The grant is combinational and
// only offered while Enable is high; LastB remembers who was served last and
// resets to 1 so that A wins the first tie.
module rr_arbiter2
  import divider_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ReqA,
  input  logic       ReqB,
  input  logic       Enable,
  output logic [1:0] grant
);

  logic last_b;

  // Pick a winner; on a tie the requester not served last goes first.
  always_comb begin
    grant = 2'b00;
    if (Enable) begin
      if (ReqA && ReqB) begin
        if (last_b) grant[REQ_A] = 1'b1;
        else        grant[REQ_B] = 1'b1;
      end else if (ReqA) begin
        grant[REQ_A] = 1'b1;
      end else if (ReqB) begin
        grant[REQ_B] = 1'b1;
      end
    end
  end

  // Record the winner on the grant edge.
  always_ff @(posedge Clk) begin
    if (Reset)               last_b <= 1'b1;
    else if (grant != 2'b00) last_b <= grant[REQ_B];
  end

endmodule

// File: rtl/divider_arbiter.sv
// divider_arbiter: shares one divider core between requesters A and B.
// Optional macro DIV_ZERO_CHECK_EN: adds DivErr and answers divide-by-zero
// jobs locally (Quotient = all ones, Remainder = dividend) without the core.
//
// state | meaning
// IDLE  | arbitrate; a grant captures the winner's operands
// LOAD  | DivStart high for one cycle
// WAIT  | operands held, waiting for DivDone
// ACK   | results captured, DivAck and the owner's Done pulse
module divider_arbiter
  import divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ReqA,
  input  logic [WIDTH-1:0] XinA,
  input  logic [WIDTH-1:0] YinA,
  input  logic             ReqB,
  input  logic [WIDTH-1:0] XinB,
  input  logic [WIDTH-1:0] YinB,
  output logic             GntA,
  output logic             GntB,
  output logic             DoneA,
  output logic             DoneB,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
`ifdef DIV_ZERO_CHECK_EN
  output logic             DivErr,
`endif
  output logic [WIDTH-1:0] DivXin,
  output logic [WIDTH-1:0] DivYin,
  output logic             DivStart,
  output logic             DivAck,
  input  logic             DivDone,
  input  logic [WIDTH-1:0] DivQuotient,
  input  logic [WIDTH-1:0] DivRemainder
);

  state_t           state_q, state_d;
  logic [1:0]       grant;
  logic             granted;
  logic             owner_b;
  logic [WIDTH-1:0] sel_x, sel_y;
  logic             zero_job;

  // Arbitration is offered only in IDLE and never while reset is applied.
  rr_arbiter2 u_arb (
    .Clk    (Clk),
    .Reset  (Reset),
    .ReqA   (ReqA),
    .ReqB   (ReqB),
    .Enable ((state_q == IDLE) && !Reset),
    .grant  (grant)
  );

  assign granted = (grant != 2'b00);
  assign GntA    = grant[REQ_A];
  assign GntB    = grant[REQ_B];
  assign Busy    = (state_q != IDLE);

  // Steer the winning requester's operands towards the capture registers.
  always_comb begin
    sel_x = grant[REQ_B] ? XinB : XinA;
    sel_y = grant[REQ_B] ? YinB : YinA;
  end

`ifdef DIV_ZERO_CHECK_EN
  logic err_q;

  assign zero_job = (sel_y == '0);
  assign DivErr   = err_q;

  // Flag a zero-divisor job from its grant until its ACK cycle ends.
  always_ff @(posedge Clk) begin
    if (Reset)                err_q <= 1'b0;
    else if (granted)         err_q <= zero_job;
    else if (state_q == ACK)  err_q <= 1'b0;
  end
`else
  logic err_q;

  assign zero_job = 1'b0;
  assign err_q    = 1'b0;
`endif

  // Next-state and handshake decode.
  always_comb begin
    state_d  = state_q;
    DivStart = 1'b0;
    DivAck   = 1'b0;
    DoneA    = 1'b0;
    DoneB    = 1'b0;
    case (state_q)
      IDLE: begin
        if (granted) state_d = zero_job ? ACK : LOAD;
      end
      LOAD: begin
        DivStart = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (DivDone) state_d = ACK;
      end
      ACK: begin
        DivAck  = !err_q;
        DoneA   = !owner_b;
        DoneB   = owner_b;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Capture operands and owner on the grant edge; held for the whole job.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      DivXin  <= '0;
      DivYin  <= '0;
      owner_b <= 1'b0;
    end else if (granted) begin
      DivXin  <= sel_x;
      DivYin  <= sel_y;
      owner_b <= grant[REQ_B];
    end
  end

  // Capture results in ACK; they stay put until the next completion.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Quotient  <= '0;
      Remainder <= '0;
    end else if (state_q == ACK) begin
      if (err_q) begin
        Quotient  <= '1;
        Remainder <= DivXin;
      end else begin
        Quotient  <= DivQuotient;
        Remainder <= DivRemainder;
      end
    end
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// tb_divider_arbiter: randomized scoreboard bench for divider_arbiter with a
// behavioural divider core, two requester drivers and a decoupled monitor.
module tb_divider_arbiter;

  localparam int W = 4;

`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
  logic DivErr;
`else
  localparam bit ZCHK = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Reset;
  logic         ReqA, ReqB;
  logic [W-1:0] XinA, YinA, XinB, YinB;
  logic         GntA, GntB, DoneA, DoneB, Busy;
  logic [W-1:0] Quotient, Remainder, DivXin, DivYin;
  logic         DivStart, DivAck, DivDone;
  logic [W-1:0] DivQuotient, DivRemainder;

  always #5 Clk = ~Clk;

  divider_arbiter #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset),
    .ReqA(ReqA), .XinA(XinA), .YinA(YinA),
    .ReqB(ReqB), .XinB(XinB), .YinB(YinB),
    .GntA(GntA), .GntB(GntB), .DoneA(DoneA), .DoneB(DoneB),
    .Quotient(Quotient), .Remainder(Remainder), .Busy(Busy),
`ifdef DIV_ZERO_CHECK_EN
    .DivErr(DivErr),
`endif
    .DivXin(DivXin), .DivYin(DivYin), .DivStart(DivStart), .DivAck(DivAck),
    .DivDone(DivDone), .DivQuotient(DivQuotient), .DivRemainder(DivRemainder)
  );

  typedef struct { logic [W-1:0] x; logic [W-1:0] y; int gap; } job_t;
  typedef struct { bit owner_b; logic [W-1:0] x; logic [W-1:0] y; } exp_t;

  job_t qa[$], qb[$];
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  bit a_active = 0, b_active = 0;
  bit model_last_b = 1;
  int start_cnt = 0, ack_cnt = 0;
  bit pending_res = 0;
  logic [W-1:0] exp_q, exp_r;

  int  core_delay = 4;
  bit  core_rand = 0;
  bit  core_busy = 0, core_fired = 0;
  int  core_cnt = 0;
  logic [W-1:0] cx, cy;

  task automatic chk_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_a(input int x, input int y, input int gap);
    job_t j;
    j.x = W'(x); j.y = W'(y); j.gap = gap;
    qa.push_back(j);
  endtask

  task automatic push_b(input int x, input int y, input int gap);
    job_t j;
    j.x = W'(x); j.y = W'(y); j.gap = gap;
    qb.push_back(j);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk_eq({tag, "_gnt"},   int'(GntA) + int'(GntB), 0);
    chk_eq({tag, "_done"},  int'(DoneA) + int'(DoneB), 0);
    chk_eq({tag, "_busy"},  int'(Busy), 0);
    chk_eq({tag, "_start"}, int'(DivStart), 0);
    chk_eq({tag, "_ack"},   int'(DivAck), 0);
    chk_eq({tag, "_xin"},   int'(DivXin), 0);
    chk_eq({tag, "_yin"},   int'(DivYin), 0);
    chk_eq({tag, "_quot"},  int'(Quotient), 0);
    chk_eq({tag, "_rem"},   int'(Remainder), 0);
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || a_active || b_active ||
            Busy || sb.size() != 0 || pending_res) && n < bound) begin
      @(negedge Clk);
      n++;
    end
    chk_eq("idle_reached", int'(n < bound), 1);
  endtask

  // Behavioural divider core: DivDone rises core_cnt cycles after the start
  // is seen and stays high until acknowledged.
  initial begin
    DivDone = 0; DivQuotient = '0; DivRemainder = '0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        DivDone = 0; core_busy = 0;
      end else begin
        if (DivDone && DivAck) begin
          DivDone = 0; core_busy = 0;
        end
        if (DivStart) begin
          cx = DivXin; cy = DivYin;
          core_cnt = core_rand ? int'($urandom_range(0, 5)) : core_delay;
          core_busy = 1; core_fired = 0;
        end else if (core_busy && !DivDone) begin
          if (core_cnt == 0) begin
            DivDone = 1; core_fired = 1;
            DivQuotient  = (cy == 0) ? {W{1'b1}} : cx / cy;
            DivRemainder = (cy == 0) ? cx : cx % cy;
          end else begin
            core_cnt--;
          end
        end
      end
    end
  end

  // Requester A: raises ReqA per queued job and holds it until GntA.
  initial begin
    job_t j;
    bit got;
    ReqA = 0; XinA = '0; YinA = '0;
    @(posedge Clk); #1;
    forever begin
      while (qa.size() == 0) begin @(posedge Clk); #1; end
      j = qa.pop_front();
      a_active = 1;
      repeat (j.gap) begin @(posedge Clk); #1; end
      ReqA = 1; XinA = j.x; YinA = j.y;
      got = 0;
      for (int c = 0; c < 3000 && !got; c++) begin
        @(negedge Clk);
        if (GntA) got = 1;
      end
      chk_eq("grant_a_seen", int'(got), 1);
      @(posedge Clk); #1;
      if (!(qa.size() > 0 && qa[0].gap == 0)) ReqA = 0;
      a_active = 0;
    end
  end

  // Requester B: same behaviour as A.
  initial begin
    job_t j;
    bit got;
    ReqB = 0; XinB = '0; YinB = '0;
    @(posedge Clk); #1;
    forever begin
      while (qb.size() == 0) begin @(posedge Clk); #1; end
      j = qb.pop_front();
      b_active = 1;
      repeat (j.gap) begin @(posedge Clk); #1; end
      ReqB = 1; XinB = j.x; YinB = j.y;
      got = 0;
      for (int c = 0; c < 3000 && !got; c++) begin
        @(negedge Clk);
        if (GntB) got = 1;
      end
      chk_eq("grant_b_seen", int'(got), 1);
      @(posedge Clk); #1;
      if (!(qb.size() > 0 && qb[0].gap == 0)) ReqB = 0;
      b_active = 0;
    end
  end

  // Monitor: predicts each grant from the round-robin rule, queues the
  // expected job and checks it when the owner's Done appears.
  always @(negedge Clk) begin
    exp_t e, d;
    bit exp_b, zj;
    if (Reset) begin
      sb.delete();
      model_last_b = 1;
      pending_res = 0;
    end else begin
      if (pending_res) begin
        chk_eq("quotient", int'(Quotient), int'(exp_q));
        chk_eq("remainder", int'(Remainder), int'(exp_r));
        pending_res = 0;
      end
      if (GntA || GntB) begin
        chk_eq("gnt_onehot", int'(GntA) + int'(GntB), 1);
        chk_eq("gnt_while_idle", int'(Busy), 0);
        exp_b = (ReqA && ReqB) ? !model_last_b : ReqB;
        chk_eq("gnt_owner_b", int'(GntB), int'(exp_b));
        chk_eq("gnt_has_req", int'(exp_b ? ReqB : ReqA), 1);
        model_last_b = exp_b;
        e.owner_b = exp_b;
        e.x = exp_b ? XinB : XinA;
        e.y = exp_b ? YinB : YinA;
        sb.push_back(e);
        start_cnt = 0; ack_cnt = 0;
      end
      if (Busy && sb.size() > 0) begin
        chk_eq("hold_xin", int'(DivXin), int'(sb[$].x));
        chk_eq("hold_yin", int'(DivYin), int'(sb[$].y));
      end
      if (DivStart) begin
        start_cnt++;
        chk_eq("start_has_job", int'(sb.size() > 0), 1);
      end
      if (DivAck) ack_cnt++;
`ifdef DIV_ZERO_CHECK_EN
      if (!(DoneA || DoneB)) chk_eq("div_err_quiet", int'(DivErr), 0);
`endif
      if (DoneA || DoneB) begin
        chk_eq("done_onehot", int'(DoneA) + int'(DoneB), 1);
        if (sb.size() == 0) begin
          chk_eq("done_spurious", 1, 0);
        end else begin
          d = sb.pop_front();
          zj = ZCHK && (d.y == 0);
          chk_eq("done_owner_b", int'(DoneB), int'(d.owner_b));
          chk_eq("start_cycles", start_cnt, zj ? 0 : 1);
          chk_eq("ack_cycles", ack_cnt, zj ? 0 : 1);
          if (!zj) chk_eq("core_finished_first", int'(core_fired), 1);
`ifdef DIV_ZERO_CHECK_EN
          chk_eq("div_err", int'(DivErr), int'(zj));
`endif
          exp_q = (d.y == 0) ? {W{1'b1}} : d.x / d.y;
          exp_r = (d.y == 0) ? d.x : d.x % d.y;
          pending_res = 1;
        end
      end
    end
  end

  initial begin
    bit seen;
    Reset = 1;
    repeat (3) @(posedge Clk);
    #1 Reset = 0;
    @(negedge Clk);
    check_zero_outputs("reset");

    // Single job: 13 / 4 with DivDone five cycles after the start.
    core_delay = 4;
    push_a(13, 4, 0);
    wait_idle(200);

    // Simultaneous requests from reset: A first, then B; a second pair goes to A.
    @(posedge Clk); #1 Reset = 1;
    @(posedge Clk); #1 Reset = 0;
    push_a(15, 2, 0); push_b(9, 3, 0);
    wait_idle(200);
    push_a(10, 3, 0); push_b(12, 5, 0);
    wait_idle(200);

    // A held continuously while B pulses.
    push_a(11, 2, 0); push_a(7, 3, 0); push_a(14, 4, 0); push_a(5, 5, 0);
    push_b(8, 3, 2);  push_b(15, 6, 5);
    wait_idle(400);

    // Reset in the middle of WAIT: the job is dropped without a Done.
    core_delay = 50;
    push_a(7, 2, 0);
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge Clk);
      if (DivStart) seen = 1;
    end
    chk_eq("mid_reset_start_seen", int'(seen), 1);
    repeat (3) @(negedge Clk);
    chk_eq("mid_reset_in_wait", int'(Busy), 1);
    @(posedge Clk); #1 Reset = 1;
    @(posedge Clk); #1 Reset = 0;
    @(negedge Clk);
    check_zero_outputs("mid_reset");
    repeat (80) @(negedge Clk);
    wait_idle(200);

    // Long single-step stall of the core.
    core_delay = 1000;
    push_b(14, 3, 0);
    repeat (500) @(negedge Clk);
    chk_eq("stall_busy", int'(Busy), 1);
    wait_idle(2000);

    // Divide by zero from B.
    core_delay = 3;
    push_b(6, 0, 0);
    wait_idle(200);

    // Random traffic on both requesters with random core latency.
    core_rand = 1;
    for (int i = 0; i < 30; i++) begin
      push_a($urandom_range(0, 15),
             ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15),
             $urandom_range(0, 4));
      push_b($urandom_range(0, 15),
             ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15),
             $urandom_range(0, 4));
    end
    wait_idle(6000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
- Shares one divider core between two requesters, A and B.
- Arbitrates between them, latches the winner's operands, sequences the core's Start/Done/Ack handshake and routes the quotient and remainder back with a one-cycle completion strobe.
- Sits between the switch/button front end (or any two clients) and the divider core.
- Runs on the full-rate clock; the core's single-step enable is passed through untouched.

Parameters:
- WIDTH, 4: operand and result width in bits.

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- ReqA  input  1  requester A wants a division; level, held until GntA.
- XinA  input  WIDTH  requester A dividend.
- YinA  input  WIDTH  requester A divisor.
- ReqB, XinB, YinB  input  1/WIDTH/WIDTH  same as above, for requester B.
- GntA, GntB  output  1  one-cycle pulse; operands captured on this edge.
- DoneA, DoneB  output  1  one-cycle pulse; Quotient and Remainder valid for the owner.
- Quotient  output  WIDTH  registered result, held until next completion.
- Remainder  output  WIDTH  registered result, held until next completion.
- Busy  output  1  high in any state other than IDLE.
- DivXin, DivYin  output  WIDTH  operands to the core, held for the whole job.
- DivStart  output  1  to the core.
- DivAck  output  1  to the core.
- DivDone  input  1  from the core.
- DivQuotient, DivRemainder  input  WIDTH  from the core.

Behaviour:
- States (binary encoded):
  - IDLE: sample requests.
  - LOAD: DivStart=1 for exactly one cycle.
  - WAIT: wait for DivDone; all Div outputs held.
  - ACK: capture results, DivAck=1 for one cycle, pulse DoneA or DoneB.
  - Sequence: IDLE -> LOAD -> WAIT -> ACK -> IDLE.
- Arbitration happens only in IDLE.
  - Single request: grant it.
  - Both requesting: grant the one not served last, tracked by a LastB flag, which resets to 1 so A wins first.
  - Grant pulse and operand capture (into DivXin/DivYin) occur on the IDLE->LOAD edge. LastB is updated on the same edge.
- WAIT->ACK on the first cycle DivDone=1.
  - No timeout; the core may be single-stepped indefinitely.
- In ACK:
  - Quotient/Remainder <= DivQuotient/DivRemainder.
  - The owner's Done pulses. The done pulse coincides with DivAck; results are visible from the next cycle and held.
- Latency: Gnt at edge 0, DivStart during cycle 1, Done pulse one cycle after DivDone is first seen.
  - Minimum turnaround from ACK to the next grant is 1 cycle, because IDLE can grant immediately.
- Requester rules:
  - A requester keeps Req high until its Gnt.
  - Req still high in the IDLE cycle after its Done is treated as a new request.
  - Req dropped before Gnt is simply not served; no error.
- Reset, including mid-operation:
  - State=IDLE, LastB=1.
  - All outputs 0: Gnt*, Done*, Busy, DivStart, DivAck, DivXin, DivYin, Quotient, Remainder.
  - Reset is shared with the core, so both restart together.
- Only one of GntA/GntB and only one of DoneA/DoneB is ever high.
- Gnt and Done never overlap for the same requester.

Optional Feature:
- Macro: DIV_ZERO_CHECK_EN.
- Defined:
  - Adds output DivErr (1 bit). It is registered, reset 0, and pulses with Done.
  - A granted job with divisor 0 goes IDLE -> ACK without touching the core: no DivStart and no DivAck.
  - Result is Quotient = all ones and Remainder = dividend.
- Not defined:
  - Divisor 0 goes to the core like any other job.
  - No DivErr port.

Decomposition:
- Shared package divider_pkg:
  - State encoding localparams: IDLE=2'b00, LOAD=2'b01, WAIT=2'b10, ACK=2'b11.
  - Requester index constants: REQ_A=0, REQ_B=1.
- One natural sub-module: rr_arbiter2.
  - Two-way round-robin with LastB register.
  - Inputs ReqA, ReqB and Enable (the IDLE condition).
  - Outputs one-hot grant.
- The FSM and datapath registers stay in divider_arbiter.

Test Plan:
1. ReqA=1, XinA=13, YinA=4; core model asserts DivDone 5 cycles after DivStart -> GntA pulse; DivXin=13, DivYin=4; DivStart 1 cycle; DivAck 1 cycle; DoneA pulse; Quotient=3, Remainder=1.
2. ReqA and ReqB high together from reset (A: 15/2, B: 9/3) -> A served first (Q=7, R=1), then B (Q=3, R=0). Next simultaneous pair -> A again, since B was last served.
3. ReqA held continuously while ReqB pulses -> grants alternate A, B, A; never two consecutive grants to A while B waits.
4. Reset asserted while in WAIT -> next cycle: Busy=0, DivStart=0, Quotient=0. No DoneA/DoneB ever issued for the aborted job.
5. Core model holds DivDone low for 1000 cycles (single-step stall) -> arbiter stays in WAIT with operands stable and no Done pulse. Completes normally when DivDone rises.
6. DIV_ZERO_CHECK_EN defined, XinB=6, YinB=0 -> no DivStart; DoneB and DivErr pulse together; Quotient=15, Remainder=6. Without the macro -> job is sent to the core normally.
